// File: rtl/store_size_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// store_size_rmw_ctrl
//
// Store engine for sw/sh/sb into word-organised data memory. A word store is
// written straight through. Half and byte stores read the containing word,
// merge the new lanes over it and write the merged word back. While busy the
// block owns the memory port.
//
// Parameters
//   MEM_LAT      cycles from a read address on mem_addr to valid mem_rdata (1..4)
//   CHECK_ALIGN  1: misaligned or illegal requests are rejected with a fault pulse
//                0: low address bits only select lanes, size 11 behaves as word
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   request strobe, only looked at while idle
//   size       in   00 word, 01 half, 10 byte, 11 illegal
//   addr       in   byte address of the store
//   B_Out      in   store data (low bits used for half/byte)
//   mem_addr   out  word-aligned memory address
//   mem_wr     out  memory write enable
//   mem_wdata  out  word written to memory
//   mem_rdata  in   memory read data
//   busy       out  high whenever the engine is not idle
//   done       out  one-cycle pulse, store committed
//   fault      out  one-cycle pulse, request rejected, memory untouched
// -----------------------------------------------------------------------------
module store_size_rmw_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] B_Out,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE,
    FAULT
  } state_t;

  state_t      state, state_n;
  logic [1:0]  size_q, size_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] b_q, b_n;
  logic [31:0] rd_q, rd_n;
  logic [2:0]  cnt, cnt_n;

  logic [31:0] mem_addr_n;
  logic        mem_wr_n;
  logic [31:0] mem_wdata_n;
  logic        busy_n;
  logic        done_n;
  logic        fault_n;

  logic        req_fault;
  logic        req_word;
  logic [3:0]  lane_en;
  logic [31:0] lane_src;
  logic [31:0] merged;

  // Classify an incoming request. With alignment checking off, the illegal
  // size code degrades to a plain word store.
  always_comb begin
    req_fault = 1'b0;
    req_word  = (size == 2'b00) || (size == 2'b11);
    if (CHECK_ALIGN) begin
      req_fault = (size == 2'b11) ||
                  ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
                  ((size == 2'b01) && addr[0]);
    end
  end

  // Next-state logic, capture of the request, and the read-latency counter.
  // The memory word is taken on the last WAIT cycle, which is exactly when
  // mem_rdata becomes valid for the address presented in READ.
  always_comb begin
    state_n = state;
    size_n  = size_q;
    addr_n  = addr_q;
    b_n     = b_q;
    rd_n    = rd_q;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          size_n = size;
          addr_n = addr;
          b_n    = B_Out;
          if (req_fault) begin
            state_n = FAULT;
          end else if (req_word) begin
            state_n = WRITE;
          end else begin
            state_n = READ;
          end
        end
      end
      READ: begin
        state_n = WAIT;
        cnt_n   = 3'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          rd_n    = mem_rdata;
          state_n = WRITE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      FAULT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane merge: each byte lane either takes the replicated store data or
  // keeps the byte read from memory. Lane 0 is the least significant byte.
  always_comb begin
    lane_en  = 4'b1111;
    lane_src = b_n;
    case (size_n)
      2'b01: begin
        lane_en  = addr_n[1] ? 4'b1100 : 4'b0011;
        lane_src = {b_n[15:0], b_n[15:0]};
      end
      2'b10: begin
        lane_en  = 4'b0001 << addr_n[1:0];
        lane_src = {4{b_n[7:0]}};
      end
      default: begin
        lane_en  = 4'b1111;
        lane_src = b_n;
      end
    endcase
    merged = 32'd0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_en[i] ? lane_src[8*i +: 8] : rd_n[8*i +: 8];
    end
  end

  // Outputs are decoded from the next state so that they come out of flops
  // and line up with the state they belong to.
  always_comb begin
    mem_addr_n  = 32'd0;
    mem_wr_n    = 1'b0;
    mem_wdata_n = 32'd0;
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
    fault_n     = (state_n == FAULT);
    if ((state_n == READ) || (state_n == WAIT) || (state_n == WRITE)) begin
      mem_addr_n = {addr_n[31:2], 2'b00};
    end
    if (state_n == WRITE) begin
      mem_wr_n    = 1'b1;
      mem_wdata_n = merged;
    end
  end

  // State, capture and output registers. Reset abandons any store in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      b_q       <= 32'd0;
      rd_q      <= 32'd0;
      cnt       <= 3'd0;
      mem_addr  <= 32'd0;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      size_q    <= size_n;
      addr_q    <= addr_n;
      b_q       <= b_n;
      rd_q      <= rd_n;
      cnt       <= cnt_n;
      mem_addr  <= mem_addr_n;
      mem_wr    <= mem_wr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= busy_n;
      done      <= done_n;
      fault     <= fault_n;
    end
  end

endmodule

// File: tb/tb_store_size_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_store_size_rmw_ctrl
//
// Three copies of the store engine share request inputs but have their own
// start strobes: unit 0 (MEM_LAT=1, aligned), unit 1 (MEM_LAT=3, aligned) and
// unit 2 (MEM_LAT=2, alignment checking off). A shared word memory model feeds
// each unit through a read-data pipeline of that unit's latency.
// -----------------------------------------------------------------------------
module tb_store_size_rmw_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        start;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [31:0]       b_out;
  logic [2:0][31:0]  mem_addr;
  logic [2:0]        mem_wr;
  logic [2:0][31:0]  mem_wdata;
  logic [2:0][31:0]  mem_rdata;
  logic [2:0]        busy;
  logic [2:0]        done;
  logic [2:0]        fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          wr_cyc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [int unsigned];
  logic [31:0] dpipe [3][4];

  always #5 clk = ~clk;

  store_size_rmw_ctrl #(.MEM_LAT(1), .CHECK_ALIGN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .size(size), .addr(addr),
    .B_Out(b_out), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]),
    .done(done[0]), .fault(fault[0])
  );

  store_size_rmw_ctrl #(.MEM_LAT(3), .CHECK_ALIGN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .size(size), .addr(addr),
    .B_Out(b_out), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]),
    .done(done[1]), .fault(fault[1])
  );

  store_size_rmw_ctrl #(.MEM_LAT(2), .CHECK_ALIGN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .size(size), .addr(addr),
    .B_Out(b_out), .mem_addr(mem_addr[2]), .mem_wr(mem_wr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]), .busy(busy[2]),
    .done(done[2]), .fault(fault[2])
  );

  function automatic int lat_of(input int u);
    case (u)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit align_of(input int u);
    return (u != 2);
  endfunction

  // Untouched words read back as a recognisable filler pattern.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA5A5_5A5A;
  endfunction

  // Read data appears MEM_LAT cycles after the address is presented.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      dpipe[i][0] <= mem_rd(mem_addr[i]);
      for (int j = 1; j < 4; j++) dpipe[i][j] <= dpipe[i][j-1];
    end
  end

  assign mem_rdata[0] = dpipe[0][0];
  assign mem_rdata[1] = dpipe[1][2];
  assign mem_rdata[2] = dpipe[2][1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one request into unit u, push the expected write, then watch the
  // unit cycle by cycle. With hold set, start stays high and the request
  // inputs are scrambled while the unit is busy.
  task automatic applyStimulus(input int u, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d, input bit hold);
    logic [31:0] wa, old, nw;
    bit          flt;
    int          wr_cyc, end_cyc;
    exp_t        e;
    flt = align_of(u) && ((sz == 2'b11) || ((sz == 2'b00) && (a[1:0] != 2'b00)) ||
                          ((sz == 2'b01) && a[0]));
    wa  = {a[31:2], 2'b00};
    old = mem_rd(wa);
    case (sz)
      2'b01: nw = a[1] ? {d[15:0], old[15:0]} : {old[31:16], d[15:0]};
      2'b10: begin
        case (a[1:0])
          2'b00:   nw = {old[31:8], d[7:0]};
          2'b01:   nw = {old[31:16], d[7:0], old[7:0]};
          2'b10:   nw = {old[31:24], d[7:0], old[15:0]};
          default: nw = {d[7:0], old[23:0]};
        endcase
      end
      default: nw = d;
    endcase
    if (flt) begin
      wr_cyc  = -1;
      end_cyc = 1;
    end else if ((sz == 2'b00) || (sz == 2'b11)) begin
      wr_cyc  = 1;
      end_cyc = 2;
    end else begin
      wr_cyc  = 2 + lat_of(u);
      end_cyc = 3 + lat_of(u);
    end
    if (!flt) begin
      e.waddr  = wa;
      e.wdata  = nw;
      e.wr_cyc = wr_cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start[u] = 1'b1;
    size     = sz;
    addr     = a;
    b_out    = d;
    @(posedge clk);
    #1;
    if (hold) begin
      size  = ~sz;
      addr  = a ^ 32'h0000_0406;
      b_out = ~d;
    end else begin
      start[u] = 1'b0;
    end
    for (int cyc = 1; cyc <= end_cyc + 2; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_u%0d_c%0d", u, cyc), busy[u], (cyc <= end_cyc));
      checkOutput($sformatf("done_u%0d_c%0d", u, cyc), done[u], ((cyc == end_cyc) && !flt));
      checkOutput($sformatf("fault_u%0d_c%0d", u, cyc), fault[u], ((cyc == end_cyc) && flt));
      if (mem_wr[u]) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("unexpected_wr_u%0d_c%0d", u, cyc), mem_wr[u], 1'b0);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("wr_cycle_u%0d", u), cyc, e.wr_cyc);
          checkOutput($sformatf("wr_addr_u%0d", u), mem_addr[u], e.waddr);
          checkOutput($sformatf("wr_data_u%0d", u), mem_wdata[u], e.wdata);
          mem[mem_addr[u]] = mem_wdata[u];
        end
      end
      if (cyc == end_cyc + 1) start[u] = 1'b0;
    end
    checkOutput($sformatf("sb_drained_u%0d", u), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    start = 3'b000;
    size  = 2'b00;
    addr  = 32'd0;
    b_out = 32'd0;
    reset = 1'b0;
    #1;
    checkOutput("rst_mem_addr", mem_addr[0], 32'd0);
    checkOutput("rst_mem_wr", mem_wr[0], 1'b0);
    checkOutput("rst_busy", busy[0], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // word store
    applyStimulus(0, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);

    // byte and half read-modify-write on the 1-cycle memory
    mem[32'h200] = 32'h1122_3344;
    applyStimulus(0, 2'b10, 32'h0000_0202, 32'hFFFF_FFAB, 1'b0);
    checkOutput("mem_after_byte", mem_rd(32'h200), 32'h11AB_3344);
    mem[32'h200] = 32'h1122_3344;
    applyStimulus(0, 2'b01, 32'h0000_0202, 32'h0000_CAFE, 1'b0);
    mem[32'h200] = 32'h1122_3344;
    applyStimulus(0, 2'b01, 32'h0000_0200, 32'h0000_CAFE, 1'b0);

    // same half store on the 3-cycle memory
    mem[32'h200] = 32'h1122_3344;
    applyStimulus(1, 2'b01, 32'h0000_0202, 32'h0000_CAFE, 1'b0);

    // rejected requests, then the same shapes with alignment checking off
    applyStimulus(0, 2'b00, 32'h0000_0102, 32'h0BAD_0001, 1'b0);
    applyStimulus(0, 2'b01, 32'h0000_0101, 32'h0BAD_0002, 1'b0);
    applyStimulus(0, 2'b11, 32'h0000_0100, 32'h0BAD_0003, 1'b0);
    checkOutput("mem_after_faults", mem_rd(32'h100), 32'hDEAD_BEEF);
    applyStimulus(2, 2'b00, 32'h0000_0102, 32'h5555_AAAA, 1'b0);
    applyStimulus(2, 2'b11, 32'h0000_0107, 32'h0102_0304, 1'b0);
    applyStimulus(2, 2'b01, 32'h0000_0203, 32'h0000_BEEF, 1'b0);
    applyStimulus(2, 2'b10, 32'h0000_0201, 32'h0000_0077, 1'b0);

    // start held and inputs changed while busy
    applyStimulus(0, 2'b00, 32'h0000_0300, 32'h1234_5678, 1'b1);
    applyStimulus(1, 2'b10, 32'h0000_0303, 32'h0000_00C3, 1'b1);
    checkOutput("hold_no_stray_write", mem_rd(32'h704), 32'hA5A5_5A5A);

    // a few random half/byte stores on both slower units
    for (int k = 0; k < 8; k++) begin
      ra = {20'd0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))};
      rs = 2'($urandom_range(1, 2));
      applyStimulus(1 + (k % 2), rs, ra, $urandom, 1'b0);
    end

    // reset asserted in the WAIT of a byte store abandons it
    mem[32'h200] = 32'h1122_3344;
    @(negedge clk);
    start[0] = 1'b1;
    size     = 2'b10;
    addr     = 32'h0000_0202;
    b_out    = 32'h0000_00EE;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wait_addr_live", mem_addr[0], 32'h0000_0200);
    reset = 1'b0;
    #1;
    checkOutput("async_mem_addr", mem_addr[0], 32'd0);
    checkOutput("async_mem_wr", mem_wr[0], 1'b0);
    checkOutput("async_mem_wdata", mem_wdata[0], 32'd0);
    checkOutput("async_busy", busy[0], 1'b0);
    checkOutput("async_done", done[0], 1'b0);
    checkOutput("async_fault", fault[0], 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abandoned_wr_c%0d", c), mem_wr[0], 1'b0);
      checkOutput($sformatf("abandoned_busy_c%0d", c), busy[0], 1'b0);
    end
    applyStimulus(0, 2'b00, 32'h0000_0204, 32'hCAFE_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
